ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

EX→MEM pipeline stage directly downstream of the parallel sub-word adder and the rest of the EX-stage ALU. It captures the EX result, control and PSA saturation status into the MEM-stage register, and owns the architectural N/Z/V flag register. It also keeps a saturating count of PSA saturation events and latches HLT. It handles stall and flush from the hazard unit.

## Interface
Parameters:
- CNT_W, 8, width of PSA saturation event counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX holds a real instruction
- ex_opcode  in  4  instruction opcode
- ex_result  in  16  ALU/PSA result
- ex_psa_err  in  1  PSA sub-word overflow flag for this result
- ex_z, ex_v, ex_n  in  1 each  ALU zero/overflow/negative for this result
- ex_store_data  in  16  store data for SW
- ex_rd  in  4  destination register
- ex_regwrite, ex_memread, ex_memwrite  in  1 each  control
- stall  in  1  hold MEM register and flags
- flush  in  1  replace incoming instruction with a bubble
- sat_clr  in  1  clear saturation counter
- mem_valid, mem_regwrite, mem_memread, mem_memwrite  out  1 each  registered control
- mem_result, mem_store_data  out  16  registered data
- mem_rd  out  4  registered destination
- mem_psa_err  out  1  registered PSA error
- flag_z, flag_v, flag_n  out  1 each  architectural flags
- sat_count  out  CNT_W  PSA saturation events, saturating
- halted  out  1  HLT has reached MEM

## Operation
- Capture: on each edge with no rst, stall or flush, the MEM register loads all ex_* fields. mem_valid is set to ex_valid.
- Bubble: ex_valid=0 is still captured. Control outputs are forced to 0 whenever the captured ex_valid=0.
- Flag update: applies only to a captured valid instruction.
  - ADD (0000) and SUB (0001): write N, Z and V.
  - XOR (0010), SLL (0100), SRA (0101), ROR (0110): write Z only; N and V hold.
  - All other opcodes: flags unchanged, including PADDSB (0111) and RED (0011).
- Saturation counter:
  - Increments when a captured valid PADDSB has ex_psa_err=1.
  - Holds at 2^CNT_W−1 once reached; no wrap.
  - sat_clr zeroes the counter.
  - sat_clr and an increment in the same cycle give a counter value of 1.
  - sat_clr acts even during stall.
- Halt:
  - A captured valid HLT (1111) sets halted.
  - After that, captures occur with forced ex_valid=0, so no further flags, counts or control propagate.
  - halted clears only on rst.
- Priority, highest first:
  - rst
  - flush: MEM register becomes a bubble; no flag update or count
  - stall: all registers, flags and counter hold (sat_clr excepted)
  - capture
- mem_psa_err is registered for every valid capture regardless of opcode. Downstream qualifies it by opcode.

## Timing
- Latency: exactly 1 cycle EX→MEM. Flags become visible the cycle after capture, so a branch in EX on the next cycle sees the new flags.
- Reset values:
  - mem_valid, all control, mem_psa_err, halted: 0
  - mem_result, mem_store_data: 0
  - mem_rd: 0
  - flag_z, flag_v, flag_n: 0
  - sat_count: 0
- Reset asserted mid-stream takes effect at the next edge and overrides stall and flush.
- A stall lasting N cycles holds every output, except sat_count under sat_clr, for N cycles. It does not drop, duplicate or reorder instructions.
- Flush during stall: flush wins, and the register becomes a bubble on that edge.

## Structure
- Shared package: 4-bit opcode constants (ADD…HLT), flag index constants, CNT_W default.
- One sub-module `wisc_flag_reg`: N/Z/V register with per-flag write enables and a hold input. It is reused by any future flag-owning stage.
- The MEM pipeline register and the counter are written inline in ex_mem_stage.

## Test plan
- Reset then ADD, ex_result=16'h0000, ex_z=1, ex_v=0, ex_n=0 → next cycle mem_result=0, flag_z=1; the following cycle XOR with ex_z=0, ex_n=1 → flag_z=0, flag_n still 0.
- PADDSB with ex_psa_err=1 for 300 consecutive valid cycles, CNT_W=8 → sat_count reaches 255 and holds; flags unchanged throughout.
- SUB with ex_v=1 while stall=1 for 3 cycles → outputs and flags hold; flag_v=1 appears only after stall drops and capture occurs.
- flush=1 together with stall=1 on a valid ADD setting Z → mem_valid=0, all control 0, flag_z unchanged.
- sat_clr with a simultaneous PADDSB ex_psa_err=1 and sat_count=17 → sat_count=1.
- HLT captured, then a valid ADD with regwrite=1 → halted=1, mem_valid=0 and mem_regwrite=0 on the following cycles; rst clears halted.

Source files
------------

// File: rtl/ex_mem_stage_pkg.sv
// Shared opcodes, flag indices and the MEM-stage register bundle.
// Imported by ex_mem_stage and wisc_flag_reg.
package ex_mem_stage_pkg;

  localparam int CNT_W_DEF = 8;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LLB    = 4'hA;
  localparam logic [3:0] OP_LHB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam int FLAG_V = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        psa_err;
    logic [3:0]  rd;
    logic [15:0] result;
    logic [15:0] store_data;
  } mem_reg_t;

  // Which of N/Z/V an opcode writes.
  function automatic logic [2:0] flag_we(input logic [3:0] op);
    logic [2:0] we;
    we = '0;
    unique case (1'b1)
      (op == OP_ADD) || (op == OP_SUB): begin
        we[FLAG_N] = 1'b1;
        we[FLAG_Z] = 1'b1;
        we[FLAG_V] = 1'b1;
      end
      (op == OP_XOR) || (op == OP_SLL) ||
      (op == OP_SRA) || (op == OP_ROR): begin
        we[FLAG_Z] = 1'b1;
      end
      default: we = '0;
    endcase
    return we;
  endfunction

endpackage

// File: rtl/wisc_flag_reg.sv
// N/Z/V flag register with per-flag write enables and a hold input.
// Ports: clk, rst (sync, high), i_hold, i_we[2:0], i_flags[2:0], o_flags[2:0].
module wisc_flag_reg
  import ex_mem_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_hold,
  input  logic [2:0] i_we,
  input  logic [2:0] i_flags,
  output logic [2:0] o_flags
);

  logic [2:0] r_flags;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= '0;
    end else if (!i_hold) begin
      for (int i = 0; i < 3; i++) begin
        if (i_we[i]) r_flags[i] <= i_flags[i];
      end
    end
  end

  assign o_flags = r_flags;

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register, flags, PSA saturation counter, halt latch.
// Ports: ex_* inputs, stall/flush/sat_clr, mem_* outputs, flags, sat_count, halted.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [3:0]       ex_opcode,
  input  logic [15:0]      ex_result,
  input  logic             ex_psa_err,
  input  logic             ex_z,
  input  logic             ex_v,
  input  logic             ex_n,
  input  logic [15:0]      ex_store_data,
  input  logic [3:0]       ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic             ex_memwrite,
  input  logic             stall,
  input  logic             flush,
  input  logic             sat_clr,
  output logic             mem_valid,
  output logic             mem_regwrite,
  output logic             mem_memread,
  output logic             mem_memwrite,
  output logic [15:0]      mem_result,
  output logic [15:0]      mem_store_data,
  output logic [3:0]       mem_rd,
  output logic             mem_psa_err,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_n,
  output logic [CNT_W-1:0] sat_count,
  output logic             halted
);

  mem_reg_t         r_mem;
  mem_reg_t         w_mem_d;
  logic             r_halted;
  logic [CNT_W-1:0] r_cnt;

  logic             w_cap;
  logic             w_valid;
  logic             w_inc;
  logic [2:0]       w_we;
  logic [2:0]       w_flags_in;
  logic [2:0]       w_flags;

  // A real capture edge; rst is handled in each register.
  assign w_cap   = !stall && !flush;
  // Once halted, everything entering MEM is a bubble.
  assign w_valid = ex_valid && !r_halted;

  always_comb begin
    w_mem_d            = '0;
    w_mem_d.valid      = w_valid;
    w_mem_d.regwrite   = w_valid && ex_regwrite;
    w_mem_d.memread    = w_valid && ex_memread;
    w_mem_d.memwrite   = w_valid && ex_memwrite;
    w_mem_d.psa_err    = w_valid && ex_psa_err;
    w_mem_d.rd         = ex_rd;
    w_mem_d.result     = ex_result;
    w_mem_d.store_data = ex_store_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem <= '0;
    end else if (flush) begin
      r_mem <= '0;
    end else if (!stall) begin
      r_mem <= w_mem_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_halted <= 1'b0;
    end else if (w_cap && w_valid && (ex_opcode == OP_HLT)) begin
      r_halted <= 1'b1;
    end
  end

  assign w_we = (w_cap && w_valid) ? flag_we(ex_opcode) : 3'b000;

  always_comb begin
    w_flags_in         = '0;
    w_flags_in[FLAG_N] = ex_n;
    w_flags_in[FLAG_Z] = ex_z;
    w_flags_in[FLAG_V] = ex_v;
  end

  wisc_flag_reg u_flags (
    .clk     (clk),
    .rst     (rst),
    .i_hold  (stall || flush),
    .i_we    (w_we),
    .i_flags (w_flags_in),
    .o_flags (w_flags)
  );

  assign w_inc = w_cap && w_valid &&
                 (ex_opcode == OP_PADDSB) && ex_psa_err;

  // Clear beats hold; a same-cycle event lands as the first count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (sat_clr) begin
      r_cnt <= w_inc ? CNT_W'(1) : '0;
    end else if (w_inc && !(&r_cnt)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign mem_valid      = r_mem.valid;
  assign mem_regwrite   = r_mem.regwrite;
  assign mem_memread    = r_mem.memread;
  assign mem_memwrite   = r_mem.memwrite;
  assign mem_psa_err    = r_mem.psa_err;
  assign mem_rd         = r_mem.rd;
  assign mem_result     = r_mem.result;
  assign mem_store_data = r_mem.store_data;
  assign flag_n         = w_flags[FLAG_N];
  assign flag_z         = w_flags[FLAG_Z];
  assign flag_v         = w_flags[FLAG_V];
  assign sat_count      = r_cnt;
  assign halted         = r_halted;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage.
// One task per scenario, inline checks.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst, ex_valid, ex_psa_err;
  logic        ex_z, ex_v, ex_n;
  logic [3:0]  ex_opcode, ex_rd;
  logic [15:0] ex_result, ex_store_data;
  logic        ex_regwrite, ex_memread, ex_memwrite;
  logic        stall, flush, sat_clr;
  logic        mem_valid, mem_regwrite;
  logic        mem_memread, mem_memwrite;
  logic [15:0] mem_result, mem_store_data;
  logic [3:0]  mem_rd;
  logic        mem_psa_err, flag_z, flag_v, flag_n;
  logic [7:0]  sat_count;
  logic        halted;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_result(ex_result), .ex_psa_err(ex_psa_err),
    .ex_z(ex_z), .ex_v(ex_v), .ex_n(ex_n),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite),
    .stall(stall), .flush(flush), .sat_clr(sat_clr),
    .mem_valid(mem_valid), .mem_regwrite(mem_regwrite),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_result(mem_result), .mem_store_data(mem_store_data),
    .mem_rd(mem_rd), .mem_psa_err(mem_psa_err),
    .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n),
    .sat_count(sat_count), .halted(halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // opcode, valid, result, {n,z,v}, psa_err, {rw,mr,mw}, rd
  task automatic drive(input logic [3:0] op, input logic v,
                       input logic [15:0] res, input logic [2:0] nzv,
                       input logic err, input logic [2:0] ctl,
                       input logic [3:0] rd);
    ex_opcode     = op;
    ex_valid      = v;
    ex_result     = res;
    {ex_n, ex_z, ex_v} = nzv;
    ex_psa_err    = err;
    {ex_regwrite, ex_memread, ex_memwrite} = ctl;
    ex_rd         = rd;
    ex_store_data = ~res;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    stall = 0; flush = 0; sat_clr = 0;
    drive(4'h0, 1'b1, 16'hABCD, 3'b111, 1'b1, 3'b111, 4'h5);
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({mem_valid, mem_regwrite, mem_memread, mem_memwrite} !== 4'b0) begin
      $display("FAIL reset_ctl got %b want 0000",
               {mem_valid, mem_regwrite, mem_memread, mem_memwrite});
      n_bad++;
    end
    n_cmp++;
    if ({mem_result, mem_store_data, mem_rd} !== 36'h0) begin
      $display("FAIL reset_data got %h want 0",
               {mem_result, mem_store_data, mem_rd});
      n_bad++;
    end
    n_cmp++;
    if ({mem_psa_err, flag_n, flag_z, flag_v, halted} !== 5'b0 ||
        sat_count !== 8'd0) begin
      $display("FAIL reset_state got %b cnt %0d want 0",
               {mem_psa_err, flag_n, flag_z, flag_v, halted}, sat_count);
      n_bad++;
    end
    rst = 1'b0;
  endtask

  task automatic test_flags();
    // ADD result 0 with Z
    drive(4'h0, 1'b1, 16'h0000, 3'b010, 1'b0, 3'b100, 4'h3);
    tick();
    n_cmp++;
    if (mem_result !== 16'h0 || flag_z !== 1'b1 || mem_valid !== 1'b1 ||
        mem_regwrite !== 1'b1 || mem_rd !== 4'h3) begin
      $display("FAIL add_z got res %h z %b v %b rw %b rd %h want 0 1 1 1 3",
               mem_result, flag_z, mem_valid, mem_regwrite, mem_rd);
      n_bad++;
    end
    // XOR: Z only, N must hold at 0
    drive(4'h2, 1'b1, 16'h8000, 3'b100, 1'b0, 3'b100, 4'h4);
    tick();
    n_cmp++;
    if ({flag_n, flag_z, flag_v} !== 3'b000 || mem_result !== 16'h8000) begin
      $display("FAIL xor_z got nzv %b res %h want 000 8000",
               {flag_n, flag_z, flag_v}, mem_result);
      n_bad++;
    end
    // SUB writes all three
    drive(4'h1, 1'b1, 16'h9000, 3'b101, 1'b0, 3'b100, 4'h4);
    tick();
    n_cmp++;
    if ({flag_n, flag_z, flag_v} !== 3'b101) begin
      $display("FAIL sub_nzv got %b want 101", {flag_n, flag_z, flag_v});
      n_bad++;
    end
    // ROR: Z set, N and V hold at 1
    drive(4'h6, 1'b1, 16'h0000, 3'b010, 1'b0, 3'b100, 4'h4);
    tick();
    n_cmp++;
    if ({flag_n, flag_z, flag_v} !== 3'b111) begin
      $display("FAIL ror_z got %b want 111", {flag_n, flag_z, flag_v});
      n_bad++;
    end
    // RED and LW leave flags alone; LW control passes
    drive(4'h3, 1'b1, 16'h1111, 3'b000, 1'b0, 3'b100, 4'h2);
    tick();
    drive(4'h8, 1'b1, 16'h2222, 3'b000, 1'b0, 3'b110, 4'h7);
    tick();
    n_cmp++;
    if ({flag_n, flag_z, flag_v} !== 3'b111 ||
        {mem_regwrite, mem_memread, mem_memwrite} !== 3'b110 ||
        mem_store_data !== 16'hDDDD) begin
      $display("FAIL noflag_ops got nzv %b ctl %b sd %h want 111 110 dddd",
               {flag_n, flag_z, flag_v},
               {mem_regwrite, mem_memread, mem_memwrite}, mem_store_data);
      n_bad++;
    end
    // Invalid ADD: captured as bubble, flags untouched
    drive(4'h0, 1'b0, 16'h3333, 3'b000, 1'b0, 3'b111, 4'h1);
    tick();
    n_cmp++;
    if (mem_valid !== 1'b0 || {mem_regwrite, mem_memread, mem_memwrite} !== 3'b0 ||
        {flag_n, flag_z, flag_v} !== 3'b111) begin
      $display("FAIL bubble got v %b ctl %b nzv %b want 0 000 111", mem_valid,
               {mem_regwrite, mem_memread, mem_memwrite}, {flag_n, flag_z, flag_v});
      n_bad++;
    end
  endtask

  task automatic test_stall();
    drive(4'h0, 1'b1, 16'h5555, 3'b010, 1'b0, 3'b100, 4'h6);
    tick();
    drive(4'h1, 1'b1, 16'h1234, 3'b001, 1'b0, 3'b100, 4'h9);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (mem_result !== 16'h5555 || mem_rd !== 4'h6 ||
          {flag_n, flag_z, flag_v} !== 3'b010) begin
        $display("FAIL stall_hold%0d got res %h rd %h nzv %b want 5555 6 010",
                 i, mem_result, mem_rd, {flag_n, flag_z, flag_v});
        n_bad++;
      end
    end
    stall = 1'b0;
    tick();
    n_cmp++;
    if (mem_result !== 16'h1234 || mem_rd !== 4'h9 ||
        {flag_n, flag_z, flag_v} !== 3'b001) begin
      $display("FAIL stall_release got res %h rd %h nzv %b want 1234 9 001",
               mem_result, mem_rd, {flag_n, flag_z, flag_v});
      n_bad++;
    end
  endtask

  task automatic test_flush();
    // Flags now Z=0; flush+stall on an ADD that would set Z
    drive(4'h0, 1'b1, 16'h0000, 3'b010, 1'b0, 3'b101, 4'h2);
    stall = 1'b1;
    flush = 1'b1;
    tick();
    stall = 1'b0;
    flush = 1'b0;
    n_cmp++;
    if (mem_valid !== 1'b0 || {mem_regwrite, mem_memread, mem_memwrite} !== 3'b0 ||
        flag_z !== 1'b0) begin
      $display("FAIL flush got v %b ctl %b z %b want 0 000 0", mem_valid,
               {mem_regwrite, mem_memread, mem_memwrite}, flag_z);
      n_bad++;
    end
  endtask

  task automatic test_saturate();
    do_reset();
    drive(4'h0, 1'b1, 16'h8000, 3'b111, 1'b0, 3'b100, 4'h1);
    tick();
    drive(4'h7, 1'b1, 16'h7F7F, 3'b000, 1'b1, 3'b100, 4'h1);
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 254) begin
        n_cmp++;
        if (sat_count !== 8'd254) begin
          $display("FAIL sat_254 got %0d want 254", sat_count);
          n_bad++;
        end
      end
    end
    n_cmp++;
    if (sat_count !== 8'd255 || {flag_n, flag_z, flag_v} !== 3'b111 ||
        mem_psa_err !== 1'b1) begin
      $display("FAIL sat_hold got cnt %0d nzv %b err %b want 255 111 1",
               sat_count, {flag_n, flag_z, flag_v}, mem_psa_err);
      n_bad++;
    end
  endtask

  task automatic test_sat_clr();
    drive(4'h0, 1'b0, 16'h0, 3'b000, 1'b0, 3'b000, 4'h0);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    n_cmp++;
    if (sat_count !== 8'd0) begin
      $display("FAIL sat_clr got %0d want 0", sat_count);
      n_bad++;
    end
    drive(4'h7, 1'b1, 16'h0101, 3'b000, 1'b1, 3'b100, 4'h1);
    repeat (17) tick();
    // Non-PADDSB error and PADDSB without error do not count
    drive(4'h0, 1'b1, 16'h0101, 3'b000, 1'b1, 3'b100, 4'h1);
    tick();
    drive(4'h7, 1'b1, 16'h0101, 3'b000, 1'b0, 3'b100, 4'h1);
    tick();
    n_cmp++;
    if (sat_count !== 8'd17) begin
      $display("FAIL sat_17 got %0d want 17", sat_count);
      n_bad++;
    end
    drive(4'h7, 1'b1, 16'h0101, 3'b000, 1'b1, 3'b100, 4'h1);
    sat_clr = 1'b1;
    tick();
    n_cmp++;
    if (sat_count !== 8'd1) begin
      $display("FAIL sat_clr_inc got %0d want 1", sat_count);
      n_bad++;
    end
    tick();
    tick();
    sat_clr = 1'b0;
    tick();
    tick();
    // Clear during stall still clears; no count while stalled
    stall = 1'b1;
    sat_clr = 1'b1;
    tick();
    stall = 1'b0;
    sat_clr = 1'b0;
    n_cmp++;
    if (sat_count !== 8'd0) begin
      $display("FAIL sat_clr_stall got %0d want 0", sat_count);
      n_bad++;
    end
  endtask

  task automatic test_halt();
    do_reset();
    drive(4'h0, 1'b1, 16'h0001, 3'b000, 1'b0, 3'b100, 4'h1);
    tick();
    drive(4'hF, 1'b1, 16'h0000, 3'b000, 1'b0, 3'b000, 4'h0);
    tick();
    n_cmp++;
    if (halted !== 1'b1 || mem_valid !== 1'b1) begin
      $display("FAIL hlt got halted %b v %b want 1 1", halted, mem_valid);
      n_bad++;
    end
    drive(4'h0, 1'b1, 16'h0000, 3'b010, 1'b0, 3'b100, 4'h3);
    tick();
    drive(4'h7, 1'b1, 16'h0000, 3'b000, 1'b1, 3'b100, 4'h3);
    tick();
    n_cmp++;
    if (halted !== 1'b1 || mem_valid !== 1'b0 || mem_regwrite !== 1'b0 ||
        flag_z !== 1'b0 || sat_count !== 8'd0) begin
      $display("FAIL post_hlt got h %b v %b rw %b z %b cnt %0d want 1 0 0 0 0",
               halted, mem_valid, mem_regwrite, flag_z, sat_count);
      n_bad++;
    end
    // rst beats stall and flush
    stall = 1'b1;
    flush = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    n_cmp++;
    if (halted !== 1'b0 || mem_valid !== 1'b0) begin
      $display("FAIL rst_halt got h %b v %b want 0 0", halted, mem_valid);
      n_bad++;
    end
    drive(4'h0, 1'b1, 16'h0000, 3'b010, 1'b0, 3'b100, 4'h3);
    tick();
    n_cmp++;
    if (mem_valid !== 1'b1 || mem_regwrite !== 1'b1 || flag_z !== 1'b1) begin
      $display("FAIL resume got v %b rw %b z %b want 1 1 1",
               mem_valid, mem_regwrite, flag_z);
      n_bad++;
    end
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    sat_clr = 1'b0;
    drive(4'h0, 1'b0, 16'h0, 3'b000, 1'b0, 3'b000, 4'h0);
    #1;
    test_reset();
    test_flags();
    test_stall();
    test_flush();
    test_saturate();
    test_sat_clr();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
